// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - MIPS 5-stage control: decode, ID/EX/MEM/WB bundles, load-use/multiply/flush stalls
// Optional feature macro: ILLEGAL_OP_TRAP_EN (adds registered ex_illegal flag)
module pipe_control_unit #(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 4,
  localparam int CTRL_W = 14 + ALUOP_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              ex_flush,
  input  logic              mem_stall,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic              ex_illegal,
`endif
  output logic              stall_id,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_wreg,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int B_MR  = 4;
  localparam int B_MUL = 11 + ALUOP_W;
  localparam int B_JAL = 13 + ALUOP_W;

  logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [4:0]        r_ex_wreg;
  logic [CNT_W-1:0]  r_mul_cnt;
  logic              r_ex_illegal;

  logic [5:0]         w_op, w_funct;
  logic [4:0]         w_rs, w_rt, w_rd;
  logic               w_dst, w_src, w_m2r, w_rw, w_mr, w_mw, w_mul, w_ze, w_jal, w_legal;
  logic [ALUOP_W-1:0] w_alu;
  logic [2:0]         w_bj;
  logic [1:0]         w_mdt;
  logic [CTRL_W-1:0]  w_dec;
  logic [4:0]         w_dec_wreg;
  logic               w_illegal, w_mul_busy, w_rt_used, w_load_use;
  logic               w_unused;

  assign w_op     = id_instr[31:26];
  assign w_rs     = id_instr[25:21];
  assign w_rt     = id_instr[20:16];
  assign w_rd     = id_instr[15:11];
  assign w_funct  = id_instr[5:0];
  assign w_unused = ^id_instr[10:6];

  always_comb begin
    w_dst   = 1'b0;
    w_src   = 1'b0;
    w_m2r   = 1'b0;
    w_rw    = 1'b0;
    w_mr    = 1'b0;
    w_mw    = 1'b0;
    w_mul   = 1'b0;
    w_ze    = 1'b0;
    w_jal   = 1'b0;
    w_alu   = '0;
    w_bj    = 3'b000;
    w_mdt   = 2'b00;
    w_legal = 1'b1;
    case (w_op)
      6'h00: begin w_m2r = 1'b1; w_rw = 1'b1; w_mul = (w_funct == 6'h18) || (w_funct == 6'h19); end
      6'h1C: begin w_m2r = 1'b1; w_rw = 1'b1; w_mul = 1'b1; w_alu = ALUOP_W'(5'b01000); end
      6'h1F: begin w_m2r = 1'b1; w_rw = 1'b1; w_alu = ALUOP_W'(5'b01001); end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_dst = 1'b1; w_src = 1'b1; w_m2r = 1'b1; w_rw = 1'b1;
        case (w_op[2:0])
          3'h0:    w_alu = ALUOP_W'(5'b00010);
          3'h1:    begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b00111); end
          3'h2:    w_alu = ALUOP_W'(5'b00101);
          3'h3:    begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b01011); end
          3'h4:    begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b00001); end
          3'h5:    begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b00011); end
          3'h6:    begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b00100); end
          default: begin w_ze = 1'b1; w_alu = ALUOP_W'(5'b01010); end
        endcase
      end
      // Width code from opcode low bits: x11 word, x01 half, x00 byte
      6'h23, 6'h21, 6'h20: begin
        w_dst = 1'b1; w_src = 1'b1; w_rw = 1'b1; w_mr = 1'b1;
        w_alu = ALUOP_W'(5'b00010);
        w_mdt = w_op[1] ? 2'b10 : {1'b0, w_op[0]};
      end
      6'h2B, 6'h29, 6'h28: begin
        w_src = 1'b1; w_mw = 1'b1;
        w_alu = ALUOP_W'(5'b00010);
        w_mdt = w_op[1] ? 2'b10 : {1'b0, w_op[0]};
      end
      6'h04: begin w_bj = 3'b001; w_alu = ALUOP_W'(5'b00001); end
      6'h05: begin w_bj = 3'b010; w_alu = ALUOP_W'(5'b00001); end
      6'h01: w_bj = 3'b100;
      6'h07: w_bj = 3'b101;
      6'h06: w_bj = 3'b110;
      6'h02: w_bj = 3'b011;
      6'h03: begin w_bj = 3'b011; w_rw = 1'b1; w_jal = 1'b1; w_alu = ALUOP_W'(5'b10000); end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_dec      = {w_jal, w_ze, w_mul, w_mdt, w_bj, w_alu, w_mw, w_mr, w_rw, w_m2r, w_src, w_dst}
                      & {CTRL_W{id_valid}};
  assign w_dec_wreg = !id_valid ? 5'd0 : w_jal ? 5'd31 : w_dst ? w_rt : w_rd;
  assign w_illegal  = id_valid & ~w_legal;

  assign w_mul_busy = (r_mul_cnt != '0);
  assign w_rt_used  = (w_op == 6'h00) || (w_op == 6'h1C) || (w_op == 6'h1F) || (w_op == 6'h04) ||
                      (w_op == 6'h05) || (w_op == 6'h2B) || (w_op == 6'h29) || (w_op == 6'h28);
  assign w_load_use = r_ex_ctrl[B_MR] && (r_ex_wreg != 5'd0) &&
                      ((r_ex_wreg == w_rs) || ((r_ex_wreg == w_rt) && w_rt_used));

  always_comb begin
    stall_id = 1'b0;
    if (Reset)           stall_id = 1'b0;
    else if (mem_stall)  stall_id = 1'b1;
    else if (w_mul_busy) stall_id = 1'b1;
    else if (ex_flush)   stall_id = 1'b0;
    else if (w_load_use) stall_id = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ex_ctrl    <= '0;
      r_mem_ctrl   <= '0;
      r_wb_ctrl    <= '0;
      r_ex_wreg    <= 5'd0;
      r_mul_cnt    <= '0;
      r_ex_illegal <= 1'b0;
    end else if (!mem_stall) begin
      r_wb_ctrl <= r_mem_ctrl;
      if (w_mul_busy) begin
        r_mem_ctrl <= '0;
        r_mul_cnt  <= r_mul_cnt - CNT_W'(1);
      end else if (ex_flush || w_load_use) begin
        r_mem_ctrl   <= r_ex_ctrl;
        r_ex_ctrl    <= '0;
        r_ex_wreg    <= 5'd0;
        r_ex_illegal <= 1'b0;
      end else begin
        r_mem_ctrl   <= r_ex_ctrl;
        r_ex_ctrl    <= w_dec;
        r_ex_wreg    <= w_dec_wreg;
        r_ex_illegal <= w_illegal;
        r_mul_cnt    <= w_dec[B_MUL] ? CNT_W'(MUL_LAT - 1) : '0;
      end
    end
  end

  assign ex_ctrl  = r_ex_ctrl;
  assign mem_ctrl = r_mem_ctrl;
  assign wb_ctrl  = r_wb_ctrl;
  assign ex_wreg  = r_ex_wreg;
`ifdef ILLEGAL_OP_TRAP_EN
  assign ex_illegal = r_ex_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = r_ex_illegal ^ r_ex_ctrl[B_JAL];
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed self-checking bench for pipe_control_unit
module tb_pipe_control_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_flush;
  logic        mem_stall;
  logic        stall_id;
  logic [18:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_wreg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        ex_illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_control_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .id_instr  (id_instr),
    .id_valid  (id_valid),
    .ex_flush  (ex_flush),
    .mem_stall (mem_stall),
`ifdef ILLEGAL_OP_TRAP_EN
    .ex_illegal(ex_illegal),
`endif
    .stall_id  (stall_id),
    .ex_ctrl   (ex_ctrl),
    .ex_wreg   (ex_wreg),
    .mem_ctrl  (mem_ctrl),
    .wb_ctrl   (wb_ctrl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [31:0] I_LW   = 32'h8E08_0000; // lw   $t0,0($s0)
  localparam logic [31:0] I_ADD  = 32'h010A_4820; // add  $t1,$t0,$t2
  localparam logic [31:0] I_MULT = 32'h0109_0018; // mult $t0,$t1
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_ADDI = 32'h200A_0005; // addi $t2,$zero,5
  localparam logic [31:0] I_ADT0 = 32'h2008_0005; // addi $t0,$zero,5
  localparam logic [31:0] I_SW   = 32'hAE28_0000; // sw   $t0,0($s1)
  localparam logic [31:0] I_BEQ  = 32'h1109_0003;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  function automatic logic [18:0] bndl(input logic jal, input logic ze, input logic mul,
                                        input logic [1:0] mdt, input logic [2:0] bj, input logic [4:0] alu,
                                        input logic mw, input logic mr, input logic rw,
                                        input logic m2r, input logic src, input logic dst);
    return {jal, ze, mul, mdt, bj, alu, mw, mr, rw, m2r, src, dst};
  endfunction

  logic [18:0] c_lw, c_add, c_mult, c_jal, c_addi, c_sw, c_beq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    c_lw   = bndl(0, 0, 0, 2'b10, 3'b000, 5'b00010, 0, 1, 1, 0, 1, 1);
    c_add  = bndl(0, 0, 0, 2'b00, 3'b000, 5'b00000, 0, 0, 1, 1, 0, 0);
    c_mult = bndl(0, 0, 1, 2'b00, 3'b000, 5'b00000, 0, 0, 1, 1, 0, 0);
    c_jal  = bndl(1, 0, 0, 2'b00, 3'b011, 5'b10000, 0, 0, 1, 0, 0, 0);
    c_addi = bndl(0, 0, 0, 2'b00, 3'b000, 5'b00010, 0, 0, 1, 1, 1, 1);
    c_sw   = bndl(0, 0, 0, 2'b10, 3'b000, 5'b00010, 1, 0, 0, 0, 1, 0);
    c_beq  = bndl(0, 0, 0, 2'b00, 3'b001, 5'b00001, 0, 0, 0, 0, 0, 0);

    Reset = 1'b1; id_instr = I_LW; id_valid = 1'b1; ex_flush = 1'b0; mem_stall = 1'b0;
    tick();
    mem_stall = 1'b1;
    tick();
    chk("rst_ex", ex_ctrl, 0);
    chk("rst_mem", mem_ctrl, 0);
    chk("rst_wb", wb_ctrl, 0);
    chk("rst_wreg", ex_wreg, 0);
    chk("rst_stall", stall_id, 0);
    Reset = 1'b0; mem_stall = 1'b0;
    tick();
    chk("lw_ex", ex_ctrl, c_lw);
    chk("lw_memread", ex_ctrl[4], 1);
    chk("lw_wreg", ex_wreg, 8);
    chk("lw_nostall", stall_id, 0);

    id_instr = I_ADD; #1;
    chk("lu_stall", stall_id, 1);
    tick();
    chk("lu_bubble_ex", ex_ctrl, 0);
    chk("lu_mem_lw", mem_ctrl, c_lw);
    chk("lu_stall_once", stall_id, 0);
    tick();
    chk("lu_add_ex", ex_ctrl, c_add);
    chk("lu_add_wreg", ex_wreg, 9);
    chk("lu_bubble_mem", mem_ctrl, 0);
    chk("lu_wb_lw", wb_ctrl, c_lw);

    id_instr = I_LW;
    tick();
    id_instr = I_ADD; ex_flush = 1'b1; #1;
    chk("fl_stall", stall_id, 0);
    tick();
    chk("fl_ex", ex_ctrl, 0);
    chk("fl_mem", mem_ctrl, c_lw);
    ex_flush = 1'b0;

    id_instr = I_LW;
    tick();
    id_instr = I_ADT0; #1;
    chk("rt_itype_nostall", stall_id, 0);
    id_instr = I_SW; #1;
    chk("rt_store_stall", stall_id, 1);
    tick();
    chk("rt_store_bubble", ex_ctrl, 0);
    tick();
    chk("sw_ex", ex_ctrl, c_sw);

    id_instr = I_MULT;
    tick();
    chk("mul_ex", ex_ctrl, c_mult);
    chk("mul_mem_sw", mem_ctrl, c_sw);
    id_instr = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall", stall_id, 1);
      tick();
      chk("mul_hold_ex", ex_ctrl, c_mult);
      chk("mul_bubble_mem", mem_ctrl, 0);
    end
    chk("mul_release", stall_id, 0);
    tick();
    chk("mul_next_ex", ex_ctrl, c_addi);
    chk("mul_to_mem", mem_ctrl, c_mult);
    chk("mul_wb_bubble", wb_ctrl, 0);

    id_instr = I_JAL;
    tick();
    chk("jal_ex", ex_ctrl, c_jal);
    chk("jal_wreg", ex_wreg, 31);
    chk("jal_bit", ex_ctrl[18], 1);
    chk("jal_rw", ex_ctrl[3], 1);
    chk("jal_bj", ex_ctrl[13:11], 3);
    id_instr = I_BEQ; mem_stall = 1'b1; #1;
    chk("ms_stall", stall_id, 1);
    tick();
    tick();
    chk("ms_ex", ex_ctrl, c_jal);
    chk("ms_mem", mem_ctrl, c_addi);
    chk("ms_wb", wb_ctrl, c_mult);
    mem_stall = 1'b0; #1;
    chk("ms_release", stall_id, 0);
    tick();
    chk("ms_beq_ex", ex_ctrl, c_beq);
    chk("ms_jal_mem", mem_ctrl, c_jal);
    chk("ms_addi_wb", wb_ctrl, c_addi);

    id_instr = I_LW; id_valid = 1'b0;
    tick();
    chk("inv_ex", ex_ctrl, 0);
    id_valid = 1'b1; id_instr = I_ILL;
    tick();
    chk("ill_ex", ex_ctrl, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_flag", ex_illegal, 1);
`endif
    id_instr = I_ADDI;
    tick();
    chk("post_ill_ex", ex_ctrl, c_addi);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_clear", ex_illegal, 0);
`endif

    id_instr = I_MULT;
    tick();
    Reset = 1'b1;
    tick();
    chk("rm_ex", ex_ctrl, 0);
    Reset = 1'b0; id_instr = I_ADDI; #1;
    chk("rm_nostall", stall_id, 0);
    tick();
    chk("rm_addi_ex", ex_ctrl, c_addi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
